// File: rtl/vga_word_fetch_if.sv
// Framebuffer read port between the word fetcher (master) and the memory (slave).
// One request is outstanding at a time; the address is held until mem_ack.
interface vga_word_fetch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/vga_word_fetch.sv
// vga_word_fetch: double-buffered framebuffer word fetcher for the VGA pixel path.
// cur drives pixel_in; nxt holds the prefetched word for the next word slot.
// Optional feature macro: VGA_FETCH_UNDERRUN_EN enables the sticky underrun flag
// and the saturating underrun counter; without it both outputs are constant 0.
module vga_word_fetch #(
    parameter int DATA_WIDTH              = 16,
    parameter int ADDR_WIDTH              = 8,
    parameter int BITS_PER_MEMORY_PIXEL_X = 4,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 4,
    parameter int GRID_WIDTH_PX           = 512,
    parameter int GRID_HEIGHT_PX          = 384,
    parameter int H_TOTAL                 = 800,
    parameter int V_TOTAL                 = 525
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    vga_word_fetch_if.master      mem,
    output logic [DATA_WIDTH-1:0] pixel_in,
    output logic                  underrun,
    output logic [7:0]            underrun_count
);
    // Screen pixels covered by one memory word, and words per grid row.
    localparam int PPW = 2 ** ($clog2(DATA_WIDTH) + BITS_PER_MEMORY_PIXEL_X);
    localparam int WPR = GRID_WIDTH_PX / PPW;

    localparam logic [9:0] GRID_X = 10'(GRID_WIDTH_PX);
    localparam logic [9:0] GRID_Y = 10'(GRID_HEIGHT_PX);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [DATA_WIDTH-1:0] cur_reg, cur_next;
    logic [DATA_WIDTH-1:0] nxt_reg, nxt_next;
    logic                  nxt_ok_reg, nxt_ok_next;
    logic                  mem_req_reg, mem_req_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    // Line whose words are being streamed, latched at the prefetch point.
    logic [9:0]            line_reg, line_next;
    logic                  line_in_grid_reg, line_in_grid_next;
    // Cleared by reset; promotions are ignored until the first prefetch point.
    logic                  active_reg, active_next;

    logic [9:0]            target_line;
    logic                  target_in_grid;
    logic [WPR-1:0]        promo_hit;
    logic                  promo_any;
    int                    promo_word;
`ifdef VGA_FETCH_UNDERRUN_EN
    logic                  underrun_event;
`endif

    // Flat word address of word 'word' on screen line 'line'.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [9:0] line, input int word);
        int flat;
        flat = int'(line >> BITS_PER_MEMORY_PIXEL_Y) * WPR + word;
        return flat[ADDR_WIDTH-1:0];
    endfunction

    assign target_line    = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
    assign target_in_grid = (target_line < GRID_Y);

    // Promotion points: slot 0 at the last column of the line, slot k one pixel before word k.
    assign promo_hit[0] = (pixel_x == H_LAST);
    genvar gi;
    generate
        for (gi = 1; gi < WPR; gi++) begin : g_promo
            assign promo_hit[gi] = (pixel_x == 10'(gi * PPW - 1));
        end
    endgenerate

    // Decode which word slot (if any) is being promoted this cycle.
    always_comb begin
        promo_any  = |promo_hit;
        promo_word = 0;
        for (int k = 0; k < WPR; k++) begin
            if (promo_hit[k]) promo_word = k;
        end
    end

    // Next-state: ack capture, line prefetch, and promotion (prefetch/promotion override ack).
    always_comb begin
        cur_next          = cur_reg;
        nxt_next          = nxt_reg;
        nxt_ok_next       = nxt_ok_reg;
        mem_req_next      = mem_req_reg;
        mem_addr_next     = mem_addr_reg;
        line_next         = line_reg;
        line_in_grid_next = line_in_grid_reg;
        active_next       = active_reg;
`ifdef VGA_FETCH_UNDERRUN_EN
        underrun_event    = 1'b0;
`endif
        if (mem_req_reg && mem.mem_ack) begin
            nxt_next     = mem.mem_rdata;
            nxt_ok_next  = 1'b1;
            mem_req_next = 1'b0;
        end

        if (pixel_x == GRID_X) begin
            active_next       = 1'b1;
            line_next         = target_line;
            line_in_grid_next = target_in_grid;
            if (target_in_grid) begin
                mem_req_next  = 1'b1;
                mem_addr_next = word_addr(target_line, 0);
                nxt_ok_next   = 1'b0;
            end else begin
                // Lines below the grid display blank; no memory traffic needed.
                nxt_next     = '0;
                nxt_ok_next  = 1'b1;
                mem_req_next = 1'b0;
            end
        end else if (active_reg && promo_any) begin
            if (nxt_ok_reg) begin
                cur_next    = nxt_reg;
                nxt_ok_next = 1'b0;
                if ((promo_word + 1 < WPR) && line_in_grid_reg) begin
                    mem_req_next  = 1'b1;
                    mem_addr_next = word_addr(line_reg, promo_word + 1);
                end
            end else begin
                // Word missed its slot: blank it and abandon the outstanding read.
                cur_next     = '0;
                nxt_ok_next  = 1'b0;
                mem_req_next = 1'b0;
`ifdef VGA_FETCH_UNDERRUN_EN
                if (line_in_grid_reg) underrun_event = 1'b1;
`endif
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            cur_reg          <= '0;
            nxt_reg          <= '0;
            nxt_ok_reg       <= 1'b0;
            mem_req_reg      <= 1'b0;
            mem_addr_reg     <= '0;
            line_reg         <= '0;
            line_in_grid_reg <= 1'b0;
            active_reg       <= 1'b0;
        end else begin
            cur_reg          <= cur_next;
            nxt_reg          <= nxt_next;
            nxt_ok_reg       <= nxt_ok_next;
            mem_req_reg      <= mem_req_next;
            mem_addr_reg     <= mem_addr_next;
            line_reg         <= line_next;
            line_in_grid_reg <= line_in_grid_next;
            active_reg       <= active_next;
        end
    end

    assign pixel_in     = cur_reg;
    assign mem.mem_req  = mem_req_reg;
    assign mem.mem_addr = mem_addr_reg;

`ifdef VGA_FETCH_UNDERRUN_EN
    logic       underrun_reg;
    logic [7:0] underrun_count_reg;

    // Sticky underrun flag and saturating event counter.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            underrun_reg       <= 1'b0;
            underrun_count_reg <= 8'd0;
        end else if (underrun_event) begin
            underrun_reg <= 1'b1;
            if (underrun_count_reg != 8'hFF) underrun_count_reg <= underrun_count_reg + 8'd1;
        end
    end

    assign underrun       = underrun_reg;
    assign underrun_count = underrun_count_reg;
`else
    assign underrun       = 1'b0;
    assign underrun_count = 8'd0;
`endif
endmodule

// File: tb/tb_vga_word_fetch.sv
// Randomized bench for vga_word_fetch against a line/word-level reference model.
module tb_vga_word_fetch;
    localparam int PPW     = 256;
    localparam int WPR     = 2;
    localparam int GRID_W  = 512;
    localparam int GRID_H  = 384;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    logic        CLK_50 = 1'b0;
    logic        RESET  = 1'b1;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [15:0] pixel_in;
    logic        underrun;
    logic [7:0]  underrun_count;

    vga_word_fetch_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) mem_bus ();

    vga_word_fetch dut (
        .CLK_50         (CLK_50),
        .RESET          (RESET),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .mem            (mem_bus),
        .pixel_in       (pixel_in),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 CLK_50 = ~CLK_50;

    int checks   = 0;
    int failures = 0;

    // Memory model and responder. ack_mode: 0 normal, 1 drop all, 2 drop odd addresses, 3 never.
    logic [15:0] mem_model [256];
    int          ack_mode    = 0;
    int          req_age     = 0;
    int          req_lat     = 1;
    logic        auto_ack    = 1'b0;
    logic [15:0] auto_data   = '0;
    logic        manual_ack  = 1'b0;
    logic [15:0] manual_data = '0;

    assign mem_bus.mem_ack   = auto_ack | manual_ack;
    assign mem_bus.mem_rdata = manual_ack ? manual_data : auto_data;

    always @(negedge CLK_50) begin
        auto_ack = 1'b0;
        if (!mem_bus.mem_req) begin
            req_age = 0;
        end else begin
            if (req_age == 0) req_lat = $urandom_range(1, 3);
            req_age++;
            if (req_age == req_lat && !(ack_mode == 1 || ack_mode == 3 ||
                                        (ack_mode == 2 && mem_bus.mem_addr[0]))) begin
                auto_ack  = 1'b1;
                auto_data = mem_model[mem_bus.mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: on a line whose predecessor was fetched, pixel_in shows the word covering x
    // (the last word through the blanking tail); lines outside the grid read as 0.
    function automatic logic [15:0] exp_pixel(input int x, input int y, input bit armed);
        int w;
        if (!armed || y >= GRID_H) return 16'h0000;
        w = x / PPW;
        if (w > WPR - 1) w = WPR - 1;
        return mem_model[((y >> 4) * WPR + w) % 256];
    endfunction

    task automatic step(input int x, input int y);
        @(negedge CLK_50);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
    endtask

    task automatic do_reset(input int y);
        @(negedge CLK_50);
        RESET   = 1'b1;
        pixel_x = 10'd0;
        pixel_y = 10'(y);
        @(negedge CLK_50);
        RESET = 1'b0;
    endtask

    task automatic run_line(input int y, input bit armed);
        int rx;
        int tgt;
        rx  = $urandom_range(0, H_TOTAL - 1);
        tgt = (y == V_TOTAL - 1) ? 0 : y + 1;
        for (int x = 0; x < H_TOTAL; x++) begin
            step(x, y);
            if (x == 0 || x == 1 || x == 255 || x == 256 || x == 511 || x == 512 ||
                x == 799 || x == rx)
                check($sformatf("pix y=%0d x=%0d", y, x), 32'(pixel_in), 32'(exp_pixel(x, y, armed)));
            if (x == 513) begin
                check($sformatf("req y=%0d", y), 32'(mem_bus.mem_req), (tgt < GRID_H) ? 32'd1 : 32'd0);
                if (tgt < GRID_H)
                    check($sformatf("addr y=%0d", y), 32'(mem_bus.mem_addr), 32'(((tgt >> 4) * WPR) % 256));
            end
            if (x == 700 && tgt >= GRID_H)
                check($sformatf("blank_req y=%0d", y), 32'(mem_bus.mem_req), 32'd0);
        end
        $display("line y=%0d armed=%0d done checks=%0d", y, armed, checks);
    endtask

    task automatic run_segment(input int y0, input int nlines);
        bit armed;
        armed = 1'b0;
        do_reset(y0);
        for (int i = 0; i < nlines; i++) begin
            run_line((y0 + i) % V_TOTAL, armed);
            armed = 1'b1;
        end
        check($sformatf("seg_underrun y0=%0d", y0), 32'(underrun), 32'd0);
        check($sformatf("seg_count y0=%0d", y0), 32'(underrun_count), 32'd0);
    endtask

    initial begin
        int exp_ur1;
        int exp_cnt1;
        int exp_cnt20;
        int exp_cnt_sat;
        int exp_ur_sat;
`ifdef VGA_FETCH_UNDERRUN_EN
        exp_ur1 = 1; exp_cnt1 = 1; exp_cnt20 = 20; exp_cnt_sat = 255; exp_ur_sat = 1;
`else
        exp_ur1 = 0; exp_cnt1 = 0; exp_cnt20 = 0; exp_cnt_sat = 0; exp_ur_sat = 0;
`endif
        for (int a = 0; a < 256; a++) mem_model[a] = 16'hA500 + 16'(a);

        // Reset state.
        repeat (3) @(negedge CLK_50);
        check("rst_pixel_in", 32'(pixel_in), 32'd0);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_count", 32'(underrun_count), 32'd0);
        RESET = 1'b0;

        // Fixed memory: line 15 -> 16 word fetch, grid bottom, and frame wrap.
        run_segment(14, 3);
        run_segment(382, 3);
        run_segment(523, 3);

        // Randomized memory contents and start lines.
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 256; a++) mem_model[a] = 16'($urandom);
            run_segment($urandom_range(0, V_TOTAL - 1), 3);
        end

        // Word-1 fetch never acked: underrun at the start of word 1, late ack ignored.
        for (int a = 0; a < 256; a++) mem_model[a] = 16'hA500 + 16'(a);
        ack_mode = 2;
        do_reset(20);
        run_line(20, 1'b0);
        for (int x = 0; x <= 300; x++) begin
            step(x, 21);
            if (x == 0) check("ur_word0", 32'(pixel_in), 32'(mem_model[2]));
            if (x == 256) begin
                check("ur_pixel", 32'(pixel_in), 32'd0);
                check("ur_flag", 32'(underrun), 32'(exp_ur1));
                check("ur_count", 32'(underrun_count), 32'(exp_cnt1));
                check("ur_req_dropped", 32'(mem_bus.mem_req), 32'd0);
            end
            if (x == 260) begin
                manual_data = 16'hBEEF;
                manual_ack  = 1'b1;
            end
            if (x == 261) manual_ack = 1'b0;
            if (x == 300) check("ur_late_ack", 32'(pixel_in), 32'd0);
        end
        $display("underrun single case done checks=%0d", checks);

        // Saturation: every fetch dropped, two underruns per line.
        ack_mode = 1;
        do_reset(40);
        for (int i = 0; i < 160; i++) begin
            int y;
            y = 40 + (i % 200);
            step(512, y);
            step(799, y);
            step(255, y + 1);
            step(300, y + 1);
            if (i == 9) check("sat_count20", 32'(underrun_count), 32'(exp_cnt20));
        end
        check("sat_count", 32'(underrun_count), 32'(exp_cnt_sat));
        check("sat_flag", 32'(underrun), 32'(exp_ur_sat));
        check("sat_pixel", 32'(pixel_in), 32'd0);
        $display("saturation case done checks=%0d", checks);

        // Reset while a request is outstanding, followed by a stray ack.
        ack_mode = 3;
        do_reset(30);
        for (int x = 0; x <= 513; x++) step(x, 30);
        check("rq_req_before", 32'(mem_bus.mem_req), 32'd1);
        RESET = 1'b1;
        step(514, 30);
        RESET = 1'b0;
        step(515, 30);
        check("rq_req_dropped", 32'(mem_bus.mem_req), 32'd0);
        check("rq_count", 32'(underrun_count), 32'd0);
        ack_mode    = 0;
        manual_data = 16'hDEAD;
        manual_ack  = 1'b1;
        step(516, 30);
        manual_ack = 1'b0;
        for (int x = 517; x < H_TOTAL; x++) begin
            step(x, 30);
            if (x == 530 || x == 799) check($sformatf("rq_pixel x=%0d", x), 32'(pixel_in), 32'd0);
        end
        run_line(31, 1'b0);
        run_line(32, 1'b1);
        check("rq_underrun", 32'(underrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_word_fetch.md
VGA_WORD_FETCH -- requirements
Module: vga_word_fetch

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 16, memory word width; ADDR_WIDTH, 8, word address width.
REQ-002 SHALL have parameters BITS_PER_MEMORY_PIXEL_X, 4 and BITS_PER_MEMORY_PIXEL_Y, 4, screen pixels per memory pixel as log2, horizontally and vertically.
REQ-003 SHALL have parameters GRID_WIDTH_PX, 512, grid width; GRID_HEIGHT_PX, 384, grid height; H_TOTAL, 800, pixel_x period; V_TOTAL, 525, pixel_y period.
REQ-004 SHALL derive PPW = 2**(clog2(DATA_WIDTH)+BITS_PER_MEMORY_PIXEL_X) screen pixels per word and WPR = GRID_WIDTH_PX/PPW words per row.
REQ-005 Ports (name, direction, width, meaning); one clock; reset is synchronous and active-high:
- CLK_50  in  1  system clock
- RESET  in  1  synchronous active-high reset
- pixel_x  in  10  current beam column from sync_gen
- pixel_y  in  10  current beam row from sync_gen
- mem_req  out  1  read request to the framebuffer port
- mem_addr  out  ADDR_WIDTH  word address of the read
- mem_ack  in  1  read done; mem_rdata valid this cycle
- mem_rdata  in  DATA_WIDTH  read data
- pixel_in  out  DATA_WIDTH  word covering pixel_x, consumed by vga
- underrun  out  1  sticky: a word was not ready in time
- underrun_count  out  8  saturating underrun count

Function
REQ-006 SHALL hold two registers: cur (drives pixel_in) and nxt (prefetch), plus nxt_ok flag.
REQ-007 Grid row of screen line L SHALL be L >> BITS_PER_MEMORY_PIXEL_Y; word address SHALL be row*WPR + w, truncated to ADDR_WIDTH.
REQ-008 Line prefetch: on the edge where pixel_x == GRID_WIDTH_PX, SHALL target line T = pixel_y+1, or 0 if pixel_y == V_TOTAL-1, word 0.
REQ-009 If T < GRID_HEIGHT_PX, SHALL issue a fetch of word 0; otherwise SHALL load nxt with 0, set nxt_ok, and issue no request.
REQ-010 Promotion SHALL occur on edges where pixel_x == H_TOTAL-1 (word 0) or pixel_x == k*PPW-1 for 1 <= k < WPR (word k), so pixel_in is valid in the first cycle of each word.
REQ-011 At promotion with nxt_ok set: cur <= nxt, nxt_ok <= 0; if word k+1 < WPR and the current line is inside the grid, SHALL issue a fetch of word k+1.
REQ-012 At promotion with nxt_ok clear (fetch still pending): cur <= 0, underrun event raised, pending fetch abandoned, its later ack ignored.
REQ-013 Handshake: mem_req SHALL rise the cycle after a fetch is issued and hold mem_addr stable until sampled mem_ack; at most one outstanding request.
REQ-014 On mem_ack with mem_req high: nxt <= mem_rdata, nxt_ok <= 1, mem_req <= 0 on the same edge. mem_ack with mem_req low SHALL be ignored.
REQ-015 A new fetch issued while one is pending SHALL replace it: address updates, mem_req stays high.
REQ-016 pixel_x >= GRID_WIDTH_PX and pixel_x < H_TOTAL-1 SHALL leave cur unchanged.

Reset
REQ-017 While RESET is high at an edge: cur, nxt, mem_addr = 0; mem_req, nxt_ok, underrun = 0; underrun_count = 0.
REQ-018 Reset mid-request SHALL drop mem_req on that edge; mem_ack arriving during or after reset for the dropped request SHALL be ignored.
REQ-019 After reset release, fetching SHALL resume at the next REQ-008 point; until then cur stays 0.

Configuration
REQ-020 Macro VGA_FETCH_UNDERRUN_EN defined: each underrun event SHALL set underrun (sticky until RESET) and increment underrun_count, saturating at 255.
REQ-021 Macro VGA_FETCH_UNDERRUN_EN undefined: underrun and underrun_count SHALL be constant 0; REQ-012 data behaviour is unchanged.

Verification
REQ-022 Memory word[a] = 16'hA500 + a, ack 2 cycles after req; line y=15 -> 16: addr 2 requested at pixel_x=512; pixel_in=16'hA502 at pixel_x=0; 16'hA503 at pixel_x=256 of line 16.
REQ-023 pixel_y=383 -> 384: no mem_req in line 383 blanking; pixel_in=0 throughout line 384.
REQ-024 mem_ack never asserted for the word-1 fetch: at pixel_x=256, pixel_in=0, underrun=1, underrun_count=1; a late ack leaves pixel_in=0.
REQ-025 Force 300 underruns with VGA_FETCH_UNDERRUN_EN defined -> underrun_count=255; same stimulus with it undefined -> both outputs 0.
REQ-026 RESET asserted one cycle while mem_req=1, then ack -> mem_req=0, pixel_in=0 until next line, no stale data loaded.
